// File: rtl/yolo_max_pool_mul_arb.sv
// yolo_max_pool_mul_arb
//   Shares one 9b x 17b unsigned multiplier among NUM_REQ requesters.
//   A granted request has its operands and index captured into internal
//   registers. The product is registered one cycle later and then held in
//   RESP until the consumer takes it. In RESP, a new request can be granted
//   in the same cycle the response is taken, which gives one product every
//   two cycles under continuous load.
//
//   Build option: define YOLO_MAX_POOL_MUL_ARB_RR_EN to get round-robin
//   arbitration. Without it, arbitration is fixed priority and the lowest
//   index wins.
//
// Ports
//   ap_clk      in   clock, all state on rising edge
//   ap_rst_n    in   asynchronous active-low reset
//   req_valid   in   [NUM_REQ]     per-requester operand valid
//   req_ready   out  [NUM_REQ]     per-requester accept strobe (one-hot or zero)
//   req_a       in   [9*NUM_REQ]   operand a, requester i at [9i+8:9i]
//   req_b       in   [17*NUM_REQ]  operand b, requester i at [17i+16:17i]
//   rsp_valid   out  product valid
//   rsp_ready   in   consumer accepts product
//   rsp_id      out  [ID_W]        requester index owning rsp_p
//   rsp_p       out  [26]          unsigned product a*b
//   busy        out  state is not IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no work in flight; grant any pending request
// COMPUTE  | operands captured; register the product on this edge
// RESP     | product held on rsp_p until taken; may grant the next request
module yolo_max_pool_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [9*NUM_REQ-1:0]  req_a,
  input  logic [17*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [25:0]           rsp_p,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        a_q, a_d;
  logic [16:0]       b_q, b_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic [25:0]       rsp_p_q, rsp_p_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_vec;
  logic              can_grant;
  logic              take;
  logic [25:0]       mul_p;

  // The single multiplier, fed only from the captured operand registers.
  assign mul_p = 26'(a_q) * 26'(b_q);

`ifdef YOLO_MAX_POOL_MUL_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  int              best_dist;
  int              dist;

  // The winner is the valid requester closest to ptr_q+1 in rotation order.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    best_dist = NUM_REQ;
    dist      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        dist = (i + NUM_REQ - 1 - int'(ptr_q)) % NUM_REQ;
        if (dist < best_dist) begin
          best_dist = dist;
          gnt_idx   = ID_W'(i);
          gnt_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take) ptr_d = gnt_idx;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) ptr_q <= ID_W'(NUM_REQ - 1);
    else           ptr_q <= ptr_d;
  end
`else
  // Scanning from the top down leaves the lowest valid index as the winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_idx   = ID_W'(i);
        gnt_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && (gnt_idx == ID_W'(i))) gnt_vec[i] = 1'b1;
    end
  end

  // req_ready is combinational from the state. It is gated by the reset
  // input so that it is also low while reset is held.
  assign can_grant = ap_rst_n &&
                     ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
  assign take      = can_grant && gnt_found;
  assign req_ready = can_grant ? gnt_vec : '0;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    rsp_p_d  = rsp_p_q;
    rsp_id_d = rsp_id_q;

    if (take) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_vec[i]) begin
          a_d = req_a[9*i +: 9];
          b_d = req_b[17*i +: 17];
        end
      end
      idx_d = gnt_idx;
    end

    case (state_q)
      ST_IDLE: begin
        if (take) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        rsp_p_d  = mul_p;
        rsp_id_d = idx_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = take ? ST_COMPUTE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      rsp_p_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      rsp_p_q  <= rsp_p_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
